// File: rtl/layer_write_manager_if.sv
// Tool-to-canvas pixel bus: the tool side presents candidate pixels,
// the canvas side receives per-layer write strobes with coordinates and colour.
interface layer_write_manager_if #(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int NUM_LAYERS  = 4,
    parameter int COLOR_WIDTH = 8
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    logic                   tool_en;
    logic [XW-1:0]          tool_x;
    logic [YW-1:0]          tool_y;
    logic [COLOR_WIDTH-1:0] tool_color;

    logic [NUM_LAYERS-1:0]  write_en;
    logic [XW-1:0]          write_x;
    logic [YW-1:0]          write_y;
    logic [COLOR_WIDTH-1:0] write_color;

    // Tool / stimulus side
    modport master (
        output tool_en, tool_x, tool_y, tool_color,
        input  write_en, write_x, write_y, write_color
    );

    // Layer write manager side
    modport slave (
        input  tool_en, tool_x, tool_y, tool_color,
        output write_en, write_x, write_y, write_color
    );
endinterface

// File: rtl/layer_write_manager.sv
// N-layer write controller for the paint pipeline: owns the active layer,
// routes tool pixels to that layer's canvas and runs raster clear sweeps
// over the current layer or all layers.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | tool writes routed to current layer, layer stepping enabled
//  CLEAR | sweep writes COLOR_NONE one pixel per cycle to the latched mask
//  DONE  | single cycle with clear_done high, then back to IDLE
//
// COLOR_WIDTH / COLOR_NONE mirror the shared paint colour definitions.
module layer_write_manager #(
    parameter int                     WIDTH       = 640,
    parameter int                     HEIGHT      = 480,
    parameter int                     NUM_LAYERS  = 4,
    parameter int                     COLOR_WIDTH = 8,
    parameter logic [COLOR_WIDTH-1:0] COLOR_NONE  = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          layer_toggle,
    input  logic                          clear_req,
    input  logic                          clear_all,
    input  logic [NUM_LAYERS-1:0]         visible,
    layer_write_manager_if.slave          bus,
    output logic [$clog2(NUM_LAYERS)-1:0] current_layer,
    output logic                          busy,
    output logic                          clear_done
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int LW = $clog2(NUM_LAYERS);

    // One extra bit so the bound itself is representable for power-of-two sizes
    localparam logic [XW:0]           X_LIM     = (XW+1)'(WIDTH);
    localparam logic [YW:0]           Y_LIM     = (YW+1)'(HEIGHT);
    localparam logic [XW-1:0]         X_LAST    = XW'(WIDTH - 1);
    localparam logic [YW-1:0]         Y_LAST    = YW'(HEIGHT - 1);
    localparam logic [LW-1:0]         L_LAST    = LW'(NUM_LAYERS - 1);
    localparam logic [NUM_LAYERS-1:0] LAYER_ONE = NUM_LAYERS'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [LW-1:0]          layer_q, layer_d;
    logic [NUM_LAYERS-1:0]  mask_q, mask_d;
    logic [XW-1:0]          x_cnt_q, x_cnt_d;
    logic [YW-1:0]          y_cnt_q, y_cnt_d;

    logic [NUM_LAYERS-1:0]  wen_q, wen_d;
    logic [XW-1:0]          wx_q, wx_d;
    logic [YW-1:0]          wy_q, wy_d;
    logic [COLOR_WIDTH-1:0] wc_q, wc_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   toggle_q, clear_q;
    logic                   toggle_rise, clear_rise;
    logic                   tool_ok;
    logic                   sweep_last;

    assign toggle_rise = layer_toggle & ~toggle_q;
    assign clear_rise  = clear_req & ~clear_q;

    assign tool_ok = bus.tool_en
                   & visible[layer_q]
                   & ({1'b0, bus.tool_x} < X_LIM)
                   & ({1'b0, bus.tool_y} < Y_LIM);

    assign sweep_last = (x_cnt_q == X_LAST) && (y_cnt_q == Y_LAST);

    // Edge detectors run in every state so edges during a sweep are consumed, not queued
    always_ff @(posedge clk) begin
        if (reset) begin
            toggle_q <= 1'b0;
            clear_q  <= 1'b0;
        end else begin
            toggle_q <= layer_toggle;
            clear_q  <= clear_req;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, sweep counters and next registered outputs
    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        mask_d  = mask_q;
        x_cnt_d = x_cnt_q;
        y_cnt_d = y_cnt_q;
        wen_d   = '0;
        wx_d    = wx_q;
        wy_d    = wy_q;
        wc_d    = wc_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (clear_rise) begin
                    // Clear wins: same-cycle toggle and tool pixel are dropped
                    mask_d  = clear_all ? '1 : (LAYER_ONE << layer_q);
                    x_cnt_d = '0;
                    y_cnt_d = '0;
                    wen_d   = mask_d;
                    wx_d    = '0;
                    wy_d    = '0;
                    wc_d    = COLOR_NONE;
                    busy_d  = 1'b1;
                    state_d = CLEAR;
                end else begin
                    if (tool_ok) begin
                        wen_d = LAYER_ONE << layer_q;
                        wx_d  = bus.tool_x;
                        wy_d  = bus.tool_y;
                        wc_d  = bus.tool_color;
                    end
                    if (toggle_rise) begin
                        layer_d = (layer_q == L_LAST) ? '0 : layer_q + LW'(1);
                    end
                end
            end

            CLEAR: begin
                if (sweep_last) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    if (x_cnt_q == X_LAST) begin
                        x_cnt_d = '0;
                        y_cnt_d = y_cnt_q + YW'(1);
                    end else begin
                        x_cnt_d = x_cnt_q + XW'(1);
                    end
                    wen_d  = mask_q;
                    wx_d   = x_cnt_d;
                    wy_d   = y_cnt_d;
                    wc_d   = COLOR_NONE;
                    busy_d = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Layer index, sweep bookkeeping and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            layer_q <= '0;
            mask_q  <= '0;
            x_cnt_q <= '0;
            y_cnt_q <= '0;
            wen_q   <= '0;
            wx_q    <= '0;
            wy_q    <= '0;
            wc_q    <= COLOR_NONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            layer_q <= layer_d;
            mask_q  <= mask_d;
            x_cnt_q <= x_cnt_d;
            y_cnt_q <= y_cnt_d;
            wen_q   <= wen_d;
            wx_q    <= wx_d;
            wy_q    <= wy_d;
            wc_q    <= wc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.write_en    = wen_q;
    assign bus.write_x     = wx_q;
    assign bus.write_y     = wy_q;
    assign bus.write_color = wc_q;
    assign current_layer   = layer_q;
    assign busy            = busy_q;
    assign clear_done      = done_q;

endmodule

// File: tb/tb_layer_write_manager.sv
// Bench for layer_write_manager: a reference model predicts every cycle's
// outputs into a queue, a monitor pops and compares after each clock edge.
// A second small instance with non-power-of-two canvas exercises the
// coordinate range check.
module tb_layer_write_manager;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int NL = 3;
    localparam int CW = 8;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);
    localparam int LW = $clog2(NL);
    localparam logic [CW-1:0] CNONE = 8'hE3;

    localparam int W2  = 5;
    localparam int H2  = 3;
    localparam int NL2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A (4x2, 3 layers) ----------------
    logic          reset;
    logic          layer_toggle;
    logic          clear_req;
    logic          clear_all;
    logic [NL-1:0] visible;
    logic [LW-1:0] current_layer;
    logic          busy;
    logic          clear_done;

    layer_write_manager_if #(.WIDTH(W), .HEIGHT(H), .NUM_LAYERS(NL), .COLOR_WIDTH(CW)) bus_a ();

    layer_write_manager #(
        .WIDTH(W), .HEIGHT(H), .NUM_LAYERS(NL), .COLOR_WIDTH(CW), .COLOR_NONE(CNONE)
    ) dut_a (
        .clk           (clk),
        .reset         (reset),
        .layer_toggle  (layer_toggle),
        .clear_req     (clear_req),
        .clear_all     (clear_all),
        .visible       (visible),
        .bus           (bus_a),
        .current_layer (current_layer),
        .busy          (busy),
        .clear_done    (clear_done)
    );

    // ---------------- instance B (5x3, 2 layers) ----------------
    logic           reset2;
    logic           toggle2;
    logic           clr2;
    logic           all2;
    logic [NL2-1:0] vis2;
    logic [0:0]     layer2;
    logic           busy2;
    logic           done2;

    layer_write_manager_if #(.WIDTH(W2), .HEIGHT(H2), .NUM_LAYERS(NL2), .COLOR_WIDTH(CW)) bus_b ();

    layer_write_manager #(
        .WIDTH(W2), .HEIGHT(H2), .NUM_LAYERS(NL2), .COLOR_WIDTH(CW), .COLOR_NONE(CNONE)
    ) dut_b (
        .clk           (clk),
        .reset         (reset2),
        .layer_toggle  (toggle2),
        .clear_req     (clr2),
        .clear_all     (all2),
        .visible       (vis2),
        .bus           (bus_b),
        .current_layer (layer2),
        .busy          (busy2),
        .clear_done    (done2)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [NL-1:0] en;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] c;
        logic          busy;
        logic          done;
        logic [LW-1:0] layer;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;
    int   cyc    = 0;

    // stimulus for the next cycle of instance A
    bit            s_rst, s_tog, s_clr, s_all, s_ten;
    logic [NL-1:0] s_vis;
    int            s_tx, s_ty;
    logic [CW-1:0] s_tc;

    // reference model state
    int            m_layer;
    int            m_left;
    bit            m_fin;
    bit            m_cool;
    bit            m_ptog, m_pclr;
    logic [NL-1:0] m_mask;
    exp_t          m_last;

    task automatic emit_pixel(inout exp_t e);
        int idx;
        idx    = W * H - m_left;
        e.en   = m_mask;
        e.x    = XW'(idx % W);
        e.y    = YW'(idx / W);
        e.c    = CNONE;
        e.busy = 1'b1;
        m_left--;
        if (m_left == 0) m_fin = 1'b1;
    endtask

    // Apply one cycle of stimulus, predict the outputs after the next edge
    task automatic step();
        exp_t e;
        bit   tr, cr;
        reset            = s_rst;
        layer_toggle     = s_tog;
        clear_req        = s_clr;
        clear_all        = s_all;
        visible          = s_vis;
        bus_a.tool_en    = s_ten;
        bus_a.tool_x     = XW'(s_tx);
        bus_a.tool_y     = YW'(s_ty);
        bus_a.tool_color = s_tc;

        if (s_rst) begin
            m_layer = 0; m_left = 0; m_fin = 0; m_cool = 0;
            m_ptog  = 0; m_pclr = 0; m_mask = '0;
            e = '0;
            e.c = CNONE;
        end else begin
            tr = s_tog && !m_ptog;
            cr = s_clr && !m_pclr;
            m_ptog = s_tog;
            m_pclr = s_clr;
            e = m_last;
            e.en = '0; e.busy = 1'b0; e.done = 1'b0;
            if (m_left > 0) begin
                emit_pixel(e);
            end else if (m_fin) begin
                m_fin  = 1'b0;
                m_cool = 1'b1;
                e.done = 1'b1;
            end else if (m_cool) begin
                m_cool = 1'b0;
            end else if (cr) begin
                m_mask = s_all ? '1 : (NL'(1) << m_layer);
                m_left = W * H;
                emit_pixel(e);
            end else begin
                if (s_ten && s_vis[m_layer] && s_tx < W && s_ty < H) begin
                    e.en = NL'(1) << m_layer;
                    e.x  = XW'(s_tx);
                    e.y  = YW'(s_ty);
                    e.c  = s_tc;
                end
                if (tr) m_layer = (m_layer + 1) % NL;
            end
        end
        e.layer = LW'(m_layer);
        m_last  = e;
        exp_q.push_back(e);
        mon_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic quiet();
        s_rst = 0; s_tog = 0; s_clr = 0; s_all = 0; s_ten = 0;
        s_vis = '1; s_tx = 0; s_ty = 0; s_tc = '0;
    endtask

    exp_t ex, act;

    // Compare DUT A outputs against the oldest prediction after each edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (mon_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow cyc=%0d no prediction queued", cyc);
            end else begin
                ex  = exp_q.pop_front();
                act = {bus_a.write_en, bus_a.write_x, bus_a.write_y, bus_a.write_color,
                       busy, clear_done, current_layer};
                if (act !== ex) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d got en=%b x=%0d y=%0d c=%h busy=%b done=%b layer=%0d want en=%b x=%0d y=%0d c=%h busy=%b done=%b layer=%0d",
                             cyc, act.en, act.x, act.y, act.c, act.busy, act.done, act.layer,
                             ex.en, ex.x, ex.y, ex.c, ex.busy, ex.done, ex.layer);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            tog_lvl, clr_lvl;
        int            bx, by;
        bit            ben, ok;
        logic [NL2-1:0] exp_en;

        quiet();
        s_rst = 1;
        reset = 1; layer_toggle = 0; clear_req = 0; clear_all = 0; visible = '1;
        bus_a.tool_en = 0; bus_a.tool_x = '0; bus_a.tool_y = '0; bus_a.tool_color = '0;
        reset2 = 1; toggle2 = 0; clr2 = 0; all2 = 0; vis2 = '1;
        bus_b.tool_en = 0; bus_b.tool_x = '0; bus_b.tool_y = '0; bus_b.tool_color = '0;
        @(negedge clk);

        // reset
        repeat (3) step();

        // single tool write at (2,1)
        quiet(); s_ten = 1; s_tx = 2; s_ty = 1; s_tc = 8'h5A; step();
        quiet(); step();

        // three toggle pulses wrap 1,2,0; held level advances once
        repeat (3) begin
            quiet(); s_tog = 1; step();
            quiet(); step();
        end
        quiet(); s_tog = 1; repeat (4) step();
        quiet(); step();

        // clear current layer (1) with tool_en held high throughout
        quiet(); s_clr = 1; s_ten = 1; s_tx = 1; s_ty = 1; s_tc = 8'h33; step();
        s_clr = 0; s_tx = 3; s_ty = 0; s_tc = 8'h44;
        repeat (11) step();

        // clear all with a same-cycle toggle edge
        quiet(); s_clr = 1; s_all = 1; s_tog = 1; s_ten = 1; s_tx = 0; s_ty = 1; step();
        quiet(); repeat (11) step();

        // hidden current layer, then visible again
        quiet(); s_vis = 3'b101; s_ten = 1; s_tx = 1; s_ty = 0; s_tc = 8'h77; step();
        quiet(); s_vis = 3'b111; s_ten = 1; s_tx = 3; s_ty = 1; s_tc = 8'h78; step();

        // reset part-way through a sweep
        quiet(); s_clr = 1; s_all = 1; step();
        quiet(); repeat (2) step();
        quiet(); s_rst = 1; step();
        quiet(); repeat (12) step();

        // randomized traffic
        tog_lvl = 0; clr_lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            s_rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) tog_lvl = ~tog_lvl;
            if ($urandom_range(0, 19) == 0) clr_lvl = ~clr_lvl;
            s_tog = tog_lvl;
            s_clr = clr_lvl;
            s_all = 1'($urandom_range(0, 1));
            s_vis = NL'($urandom);
            s_ten = ($urandom_range(0, 9) < 7);
            s_tx  = $urandom_range(0, W - 1);
            s_ty  = $urandom_range(0, H - 1);
            s_tc  = CW'($urandom);
            step();
        end
        mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d predictions unconsumed want 0", exp_q.size());
        end

        // instance B: coordinate range check on a 5x3 canvas, layer 0
        reset2 = 0;
        for (int i = 0; i < 60; i++) begin
            case (i)
                0: begin bx = 5; by = 1; ben = 1; vis2 = 2'b11; end
                1: begin bx = 4; by = 2; ben = 1; vis2 = 2'b11; end
                2: begin bx = 0; by = 3; ben = 1; vis2 = 2'b11; end
                3: begin bx = 2; by = 1; ben = 1; vis2 = 2'b10; end
                default: begin
                    bx = $urandom_range(0, 7); by = $urandom_range(0, 3);
                    ben = ($urandom_range(0, 3) != 0); vis2 = NL2'($urandom);
                end
            endcase
            bus_b.tool_en    = ben;
            bus_b.tool_x     = 3'(bx);
            bus_b.tool_y     = 2'(by);
            bus_b.tool_color = CW'(i);
            ok     = ben && vis2[0] && bx < W2 && by < H2;
            exp_en = ok ? 2'b01 : 2'b00;
            @(posedge clk);
            #1;
            checks++;
            if (bus_b.write_en !== exp_en ||
                (ok && (bus_b.write_x !== 3'(bx) || bus_b.write_y !== 2'(by)))) begin
                errors++;
                $display("FAIL range_b i=%0d in=(%0d,%0d) got en=%b x=%0d y=%0d want en=%b",
                         i, bx, by, bus_b.write_en, bus_b.write_x, bus_b.write_y, exp_en);
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
